vga: RTL and testbench

- Self-contained VGA timing generator and test-pattern source for a 640x480 @ 60 Hz display.
- Runs from the 50 MHz board clock; derives a 25 MHz pixel-rate enable internally.
- Drives 1-bit red/green/blue plus active-low hSync/vSync directly to the VGA connector.
- Pattern is eight full-height vertical colour bars; blanked outside the visible area.

---
 rtl/vga.sv | 120 ++++++++++++
 tb/tb_vga.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/vga.sv
// 640x480 @ 60 Hz VGA timing generator driving eight full-height colour bars.
// A 25 MHz pixel enable is derived from the 50 MHz clock; all five outputs are registered together.
module vga #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int BAR_WIDTH = 80
) (
    input  logic clk50,
    input  logic reset,
    output logic red,
    output logic green,
    output logic blue,
    output logic vSync,
    output logic hSync
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int SW      = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_FIRST   = HW'(H_VISIBLE + H_FP);
    localparam logic [HW-1:0] HS_LAST    = HW'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_END  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_FIRST   = VW'(V_VISIBLE + V_FP);
    localparam logic [VW-1:0] VS_LAST    = VW'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [SW-1:0] SUB_LAST   = SW'(BAR_WIDTH - 1);

    logic          pix_en;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic [SW-1:0] sub_count;
    logic [2:0]    bar;

    logic          h_wrap;
    logic          v_wrap;
    logic          visible;
    logic          h_sync_zone;
    logic          v_sync_zone;
    logic [2:0]    colour;

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            pix_en <= 1'b0;
        end else begin
            pix_en <= ~pix_en;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        h_wrap      = 1'b0;
        v_wrap      = 1'b0;
        visible     = 1'b0;
        h_sync_zone = 1'b0;
        v_sync_zone = 1'b0;
        colour      = 3'b000;

        h_wrap      = (hcount == H_LAST);
        v_wrap      = (vcount == V_LAST);
        visible     = (hcount < H_VIS_END) && (vcount < V_VIS_END);
        h_sync_zone = (hcount >= HS_FIRST) && (hcount <= HS_LAST);
        v_sync_zone = (vcount >= VS_FIRST) && (vcount <= VS_LAST);
        // Bars run white..black left to right, i.e. colour = 7 - bar index.
        if (visible) begin
            colour = ~bar;
        end
    end

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            hcount    <= '0;
            vcount    <= '0;
            sub_count <= '0;
            bar       <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                hcount    <= '0;
                sub_count <= '0;
                bar       <= '0;
                vcount    <= v_wrap ? '0 : vcount + 1'b1;
            end else begin
                hcount <= hcount + 1'b1;
                if (sub_count == SUB_LAST) begin
                    sub_count <= '0;
                    bar       <= bar + 1'b1;
                end else begin
                    sub_count <= sub_count + 1'b1;
                end
            end
        end
    end

    // Outputs decode the counters one pixel tick late, keeping sync and colour aligned.
    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            red   <= 1'b0;
            green <= 1'b0;
            blue  <= 1'b0;
            hSync <= 1'b1;
            vSync <= 1'b1;
        end else if (pix_en) begin
            {red, green, blue} <= colour;
            hSync              <= ~h_sync_zone;
            vSync              <= ~v_sync_zone;
        end
    end

endmodule

// File: tb/tb_vga.sv
// Directed bench for the VGA bar generator: reset values, line/frame timing, bar colours,
// blanking and mid-line reset recovery, all measured in clk50 cycles.
module tb_vga;

    localparam int LINE  = 1600;       // clk50 cycles per line
    localparam int V_VIS = 6;
    localparam int V_TOT = 12;         // 6 + 2 + 2 + 2 lines
    localparam int FRAME = LINE * V_TOT;

    logic clk50 = 1'b0;
    logic reset = 1'b0;
    logic red, green, blue, vSync, hSync;
    logic [2:0] rgb;

    assign rgb = {red, green, blue};

    // Vertical timing is shortened so two full frames fit in a short run; horizontal is full size.
    vga #(
        .V_VISIBLE(V_VIS),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (2)
    ) dut (
        .clk50(clk50),
        .reset(reset),
        .red  (red),
        .green(green),
        .blue (blue),
        .vSync(vSync),
        .hSync(hSync)
    );

    always #10 clk50 = ~clk50;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int hs_fall = 0, hs_fall_prev = 0, hs_rise = 0;
    int vs_fall = 0, vs_fall_prev = 0, vs_rise = 0, vs_hs_gap = -1;
    int rgb_on = 0, blank_viol = 0;
    logic hs_prev = 1'b1, vs_prev = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clk50 cycle, sample 1 ns after the edge and log sync edges.
    task automatic tick();
        @(posedge clk50);
        cyc++;
        #1;
        if (hs_prev && !hSync) begin
            hs_fall_prev = hs_fall;
            hs_fall      = cyc;
        end
        if (!hs_prev && hSync) hs_rise = cyc;
        if (vs_prev && !vSync) begin
            vs_fall_prev = vs_fall;
            vs_fall      = cyc;
            vs_hs_gap    = cyc - hs_fall;
        end
        if (!vs_prev && vSync) vs_rise = cyc;
        if (rgb != 3'b000) rgb_on++;
        if (reset && (!hSync || !vSync) && rgb != 3'b000) blank_viol++;
        hs_prev = hSync;
        vs_prev = vSync;
    endtask

    task automatic run_until(input int t);
        while (cyc < t) tick();
    endtask

    initial begin
        int t0;
        int t_rel;
        int lat;

        // Reset held for 100 ns.
        repeat (5) tick();
        check("reset_hsync", 32'(hSync), 1);
        check("reset_vsync", 32'(vSync), 1);
        check("reset_rgb",   32'(rgb),   0);

        @(negedge clk50);
        reset = 1'b1;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (rgb == 3'b111) begin
                lat = k;
                break;
            end
        end
        check("first_pixel_latency", lat, 2);
        t0 = cyc;

        // Line 0: eight bars of 160 cycles, then blanking and sync.
        for (int c = 1; c < LINE; c++) begin
            tick();
            if (c < 1280 && (c % 160 == 0 || c % 160 == 159))
                check($sformatf("bar_%0d_at_%0d", c / 160, c), 32'(rgb), 32'(7 - c / 160));
            if (c == 1280) check("blank_after_visible", 32'(rgb), 0);
        end
        check("hsync_fall_after_visible", hs_fall - t0, 1312);
        check("hsync_low_width", hs_rise - hs_fall, 192);

        tick();
        check("line1_first_pixel", 32'(rgb), 7);
        run_until(t0 + LINE + 1400);
        check("hsync_period", hs_fall - hs_fall_prev, LINE);

        // Vertical blanking and two full frames.
        run_until(t0 + (V_VIS - 1) * LINE);
        check("last_visible_line", 32'(rgb), 7);
        run_until(t0 + V_VIS * LINE);
        check("first_blank_line", 32'(rgb), 0);
        run_until(t0 + FRAME - 1);
        rgb_on = 0;
        run_until(t0 + FRAME);
        check("frame1_first_pixel", 32'(rgb), 7);
        run_until(t0 + 2 * FRAME - 1);
        check("lit_cycles_per_frame", rgb_on, V_VIS * 7 * 160);
        run_until(t0 + 2 * FRAME + 100);
        check("vsync_fall_position", vs_fall - t0, FRAME + 8 * LINE);
        check("vsync_period", vs_fall - vs_fall_prev, FRAME);
        check("vsync_low_width", vs_rise - vs_fall, 3200);
        check("vsync_on_line_boundary", vs_hs_gap, LINE - 1312);
        check("rgb_during_sync", blank_viol, 0);

        // Mid-line reset during hSync low, held 3 cycles.
        run_until(t0 + 2 * FRAME + LINE + 1400);
        check("pre_reset_hsync", 32'(hSync), 0);
        @(negedge clk50);
        reset = 1'b0;
        #1;
        check("async_reset_hsync", 32'(hSync), 1);
        check("async_reset_rgb",   32'(rgb),   0);
        repeat (3) tick();
        check("held_reset_vsync", 32'(vSync), 1);
        @(negedge clk50);
        reset = 1'b1;
        t_rel = cyc;
        run_until(t_rel + 2);
        check("restart_first_pixel", 32'(rgb), 7);
        run_until(t_rel + 1400);
        // One cycle for the enable to rise, one for the first pixel, then 1312 to the sync edge.
        check("restart_hsync_fall", hs_fall - t_rel, 2 + 1312);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
